// File: rtl/pipeline_hazard_unit_if.sv
// Signal bundle between the datapath/control and the hazard unit.
// The master drives pipeline state; the slave (hazard unit) returns stall, flush, freeze and forwarding.
interface pipeline_hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_uses_rs1;
  logic             i_id_uses_rs2;
  logic [4:0]       i_ex_rs1;
  logic [4:0]       i_ex_rs2;
  logic [4:0]       i_ex_rd;
  logic             i_ex_is_load;
  logic [4:0]       i_mem_rd;
  logic             i_mem_reg_write;
  logic [4:0]       i_wb_rd;
  logic             i_wb_reg_write;
  logic             i_branch_taken;
  logic             i_jump_taken;
  logic             i_dmem_req;
  logic             i_dmem_ready;
  logic             o_hazard_stall;
  logic             o_hazard_flush;
  logic             o_if_id_flush;
  logic             o_freeze;
  logic [1:0]       o_fwd_a;
  logic [1:0]       o_fwd_b;
  logic             o_mem_timeout;
  logic [CNT_W-1:0] o_stall_cycles;
  logic [CNT_W-1:0] o_flush_count;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_is_load,
           i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write,
           i_branch_taken, i_jump_taken, i_dmem_req, i_dmem_ready,
    input  o_hazard_stall, o_hazard_flush, o_if_id_flush, o_freeze,
           o_fwd_a, o_fwd_b, o_mem_timeout, o_stall_cycles, o_flush_count
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_is_load,
           i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write,
           i_branch_taken, i_jump_taken, i_dmem_req, i_dmem_ready,
    output o_hazard_stall, o_hazard_flush, o_if_id_flush, o_freeze,
           o_fwd_a, o_fwd_b, o_mem_timeout, o_stall_cycles, o_flush_count
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and operand forwarding for the 5-stage core, with a data-memory
// wait FSM that freezes the pipeline, a sticky timeout error and two perf counters.
module pipeline_hazard_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pipeline_hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam int                WCNT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic       mem_wait;
  logic       redirect;
  logic       load_use;
  logic       freeze;
  logic       hazard_stall;
  logic       hazard_flush;
  logic       if_id_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // The youngest producer (MEM) wins over the older one (WB); x0 is never forwarded.
  function automatic logic [1:0] fwd_src(input logic [4:0] rs,
                                         input logic       mem_we,
                                         input logic [4:0] mem_rd,
                                         input logic       wb_we,
                                         input logic [4:0] wb_rd);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
      return 2'b01;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign mem_wait = hz.i_dmem_req && !hz.i_dmem_ready;
  assign redirect = hz.i_branch_taken || hz.i_jump_taken;
  assign load_use = hz.i_ex_is_load && (hz.i_ex_rd != 5'd0) &&
                    ((hz.i_id_uses_rs1 && (hz.i_id_rs1 == hz.i_ex_rd)) ||
                     (hz.i_id_uses_rs2 && (hz.i_id_rs2 == hz.i_ex_rd)));

  // NOTE: every sequential element updates with non-blocking assignments so all flops
  // sample pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // NOTE: each combinational output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_wait) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Priority: freeze > redirect > load-use. Everything is held at 0 while reset is high.
  always_comb begin
    freeze       = 1'b0;
    hazard_stall = 1'b0;
    hazard_flush = 1'b0;
    if_id_flush  = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    if (!i_reset) begin
      freeze = (state_q == ST_ERROR) || mem_wait;
      fwd_a  = fwd_src(hz.i_ex_rs1, hz.i_mem_reg_write, hz.i_mem_rd,
                       hz.i_wb_reg_write, hz.i_wb_rd);
      fwd_b  = fwd_src(hz.i_ex_rs2, hz.i_mem_reg_write, hz.i_mem_rd,
                       hz.i_wb_reg_write, hz.i_wb_rd);
      if (!freeze) begin
        if (redirect) begin
          if_id_flush  = 1'b1;
          hazard_flush = 1'b1;
        end else if (load_use) begin
          hazard_stall = 1'b1;
          hazard_flush = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(hazard_stall || freeze);
    flush_cnt_d = flush_cnt_q + CNT_W'(if_id_flush);
  end

  assign hz.o_hazard_stall = hazard_stall;
  assign hz.o_hazard_flush = hazard_flush;
  assign hz.o_if_id_flush  = if_id_flush;
  assign hz.o_freeze       = freeze;
  assign hz.o_fwd_a        = fwd_a;
  assign hz.o_fwd_b        = fwd_b;
  assign hz.o_mem_timeout  = (state_q == ST_ERROR);
  assign hz.o_stall_cycles = stall_cnt_q;
  assign hz.o_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: hand-written table, directed corner
// sequences and random stimulus against a cycle-level reference model.
module tb_pipeline_hazard_unit;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MOD     = 1 << CNT_W;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_u1;
    logic       id_u2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic [4:0] mem_rd;
    logic       mem_wr;
    logic [4:0] wb_rd;
    logic       wb_wr;
    logic       br;
    logic       jmp;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic       ifid;
    logic       freeze;
    logic [1:0] fa;
    logic [1:0] fb;
  } comb_t;

  typedef struct packed {
    in_t   in;
    comb_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_unit #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .hz     (hz)
  );

  int    n_vec = 0;
  int    n_err = 0;
  // Reference model state: sticky error, run length of not-ready cycles, counters.
  bit    m_err;
  int    m_consec;
  int    m_stall_cnt;
  int    m_flush_cnt;
  comb_t last;
  logic  last_to;
  in_t   idle;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(in_t v);
    hz.i_id_rs1        = v.id_rs1;
    hz.i_id_rs2        = v.id_rs2;
    hz.i_id_uses_rs1   = v.id_u1;
    hz.i_id_uses_rs2   = v.id_u2;
    hz.i_ex_rs1        = v.ex_rs1;
    hz.i_ex_rs2        = v.ex_rs2;
    hz.i_ex_rd         = v.ex_rd;
    hz.i_ex_is_load    = v.ex_load;
    hz.i_mem_rd        = v.mem_rd;
    hz.i_mem_reg_write = v.mem_wr;
    hz.i_wb_rd         = v.wb_rd;
    hz.i_wb_reg_write  = v.wb_wr;
    hz.i_branch_taken  = v.br;
    hz.i_jump_taken    = v.jmp;
    hz.i_dmem_req      = v.req;
    hz.i_dmem_ready    = v.rdy;
  endtask

  function automatic comb_t dut_comb();
    comb_t c;
    c.stall  = hz.o_hazard_stall;
    c.flush  = hz.o_hazard_flush;
    c.ifid   = hz.o_if_id_flush;
    c.freeze = hz.o_freeze;
    c.fa     = hz.o_fwd_a;
    c.fb     = hz.o_fwd_b;
    return c;
  endfunction

  function automatic logic [1:0] fwd_of(in_t v, logic [4:0] r);
    if (v.mem_wr && v.mem_rd != 5'd0 && v.mem_rd == r) return 2'b01;
    if (v.wb_wr && v.wb_rd != 5'd0 && v.wb_rd == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic comb_t model_comb(in_t v);
    comb_t c;
    bit    lu;
    c        = '0;
    c.freeze = m_err || (v.req && !v.rdy);
    c.fa     = fwd_of(v, v.ex_rs1);
    c.fb     = fwd_of(v, v.ex_rs2);
    lu = v.ex_load && v.ex_rd != 5'd0 &&
         ((v.id_u1 && v.id_rs1 == v.ex_rd) || (v.id_u2 && v.id_rs2 == v.ex_rd));
    if (!c.freeze) begin
      if (v.br || v.jmp) begin
        c.ifid  = 1'b1;
        c.flush = 1'b1;
      end else if (lu) begin
        c.stall = 1'b1;
        c.flush = 1'b1;
      end
    end
    return c;
  endfunction

  // Called just after a rising edge; checks at the falling edge, advances the model at the next rise.
  task automatic step(string name, in_t v);
    comb_t e;
    drive(v);
    @(negedge clk);
    e       = model_comb(v);
    last    = dut_comb();
    last_to = hz.o_mem_timeout;
    check({name, " comb"},      32'(last), 32'(e));
    check({name, " timeout"},   32'(last_to), 32'(m_err));
    check({name, " stall_cnt"}, 32'(hz.o_stall_cycles), 32'(m_stall_cnt));
    check({name, " flush_cnt"}, 32'(hz.o_flush_count), 32'(m_flush_cnt));
    @(posedge clk);
    if (e.stall || e.freeze) m_stall_cnt = (m_stall_cnt + 1) % CNT_MOD;
    if (e.ifid)              m_flush_cnt = (m_flush_cnt + 1) % CNT_MOD;
    if (!m_err) begin
      if (v.req && !v.rdy) begin
        m_consec++;
        if (m_consec >= MEM_TIMEOUT) m_err = 1'b1;
      end else begin
        m_consec = 0;
      end
    end
    #1;
  endtask

  // Asserts reset between edges with every hazard input active; outputs must drop at once.
  task automatic do_reset(string name);
    in_t busy;
    busy         = idle;
    busy.ex_load = 1'b1;
    busy.ex_rd   = 5'd2;
    busy.id_rs1  = 5'd2;
    busy.id_u1   = 1'b1;
    busy.br      = 1'b1;
    busy.req     = 1'b1;
    busy.rdy     = 1'b0;
    busy.ex_rs1  = 5'd3;
    busy.mem_rd  = 5'd3;
    busy.mem_wr  = 1'b1;
    drive(busy);
    #2;
    rst = 1'b1;
    #1;
    check({name, " all zero"},
          32'({dut_comb(), hz.o_mem_timeout, hz.o_stall_cycles, hz.o_flush_count}), 32'd0);
    m_err       = 1'b0;
    m_consec    = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    drive(idle);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t t;
    in_t  v;

    idle     = '0;
    idle.rdy = 1'b1;
    rst      = 1'b1;
    drive(idle);
    @(posedge clk);
    #1;
    do_reset("initial reset");

    // Load x5 in EX, add in ID reads x5: one bubble, then forward from WB.
    v = idle; v.ex_load = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd6; v.id_u1 = 1'b1;
    v.id_rs2 = 5'd5; v.id_u2 = 1'b1;
    step("lu cycle1", v);
    check("lu bubble stall", 32'(last.stall), 32'd1);
    check("lu bubble flush", 32'(last.flush), 32'd1);
    v = idle; v.mem_rd = 5'd5; v.mem_wr = 1'b1; v.id_rs1 = 5'd6; v.id_u1 = 1'b1;
    v.id_rs2 = 5'd5; v.id_u2 = 1'b1;
    step("lu cycle2", v);
    check("lu no second bubble", 32'({last.stall, last.flush}), 32'd0);
    v = idle; v.ex_rs1 = 5'd6; v.ex_rs2 = 5'd5; v.wb_rd = 5'd5; v.wb_wr = 1'b1;
    step("lu cycle3", v);
    check("lu fwd_b from WB", 32'(last.fb), 32'd2);
    check("lu stall_cycles", 32'(hz.o_stall_cycles), 32'd1);

    // Branch wins over a simultaneous load-use.
    do_reset("reset before branch");
    check("br flush_count before", 32'(hz.o_flush_count), 32'd0);
    v = idle; v.br = 1'b1; v.ex_load = 1'b1; v.ex_rd = 5'd8; v.id_rs1 = 5'd8; v.id_u1 = 1'b1;
    step("br over lu", v);
    check("br redirect outputs", 32'({last.stall, last.flush, last.ifid}), 32'b011);
    check("br flush_count after", 32'(hz.o_flush_count), 32'd1);

    // Three not-ready cycles with a branch held; redirect lands when ready rises.
    do_reset("reset before freeze");
    for (int i = 0; i < 3; i++) begin
      v = idle; v.req = 1'b1; v.rdy = 1'b0; v.br = 1'b1;
      step("freeze wait", v);
      check("freeze asserted", 32'({last.freeze, last.ifid, last.flush}), 32'b100);
    end
    v = idle; v.req = 1'b1; v.rdy = 1'b1; v.br = 1'b1;
    step("freeze release", v);
    check("release redirect", 32'({last.freeze, last.ifid, last.flush}), 32'b011);
    check("freeze stall_cycles", 32'(hz.o_stall_cycles), 32'd3);
    check("freeze flush_count", 32'(hz.o_flush_count), 32'd1);

    // Ready held low: error from cycle MEM_TIMEOUT, sticky after ready returns, then reset mid-error.
    do_reset("reset before timeout");
    for (int i = 0; i < 6; i++) begin
      v = idle; v.req = 1'b1; v.rdy = 1'b0;
      step("timeout wait", v);
      check("timeout flag", 32'(last_to), (i >= MEM_TIMEOUT) ? 32'd1 : 32'd0);
    end
    v = idle; v.req = 1'b1; v.rdy = 1'b1; v.br = 1'b1;
    step("error after ready", v);
    check("error holds freeze", 32'({last.freeze, last.ifid, last_to}), 32'b101);
    do_reset("reset in error");

    // Counter wrap: 17 stall cycles on a 4-bit counter.
    v = idle; v.ex_load = 1'b1; v.ex_rd = 5'd4; v.id_rs2 = 5'd4; v.id_u2 = 1'b1;
    for (int i = 0; i < 17; i++) step("wrap stall", v);
    check("stall_cycles wrap", 32'(hz.o_stall_cycles), 32'd1);

    // Single-cycle table: forwarding cases and load-use qualifiers.
    do_reset("reset before table");
    t = '0; t.in = idle; t.in.ex_rs1 = 5'd3; t.in.mem_rd = 5'd3; t.in.mem_wr = 1'b1;
    t.in.wb_rd = 5'd3; t.in.wb_wr = 1'b1; t.exp.fa = 2'b01; tbl.push_back(t);
    t = '0; t.in = idle; t.in.ex_rs1 = 5'd3; t.in.mem_rd = 5'd0; t.in.mem_wr = 1'b1;
    t.in.wb_rd = 5'd3; t.in.wb_wr = 1'b1; t.exp.fa = 2'b10; tbl.push_back(t);
    t = '0; t.in = idle; t.in.ex_rs1 = 5'd0; t.in.mem_rd = 5'd0; t.in.mem_wr = 1'b1;
    t.in.wb_rd = 5'd0; t.in.wb_wr = 1'b1; tbl.push_back(t);
    t = '0; t.in = idle; t.in.ex_rs2 = 5'd7; t.in.mem_rd = 5'd7; t.in.mem_wr = 1'b0;
    t.in.wb_rd = 5'd7; t.in.wb_wr = 1'b1; t.exp.fb = 2'b10; tbl.push_back(t);
    t = '0; t.in = idle; t.in.ex_rs1 = 5'd4; t.in.ex_rs2 = 5'd4; t.in.mem_rd = 5'd4;
    t.in.mem_wr = 1'b1; t.exp.fa = 2'b01; t.exp.fb = 2'b01; tbl.push_back(t);
    t = '0; t.in = idle; t.in.ex_load = 1'b1; t.in.ex_rd = 5'd9; t.in.id_rs1 = 5'd9;
    t.in.id_u1 = 1'b1; t.exp.stall = 1'b1; t.exp.flush = 1'b1; tbl.push_back(t);
    t = '0; t.in = idle; t.in.ex_load = 1'b1; t.in.ex_rd = 5'd9; t.in.id_rs1 = 5'd9;
    t.in.id_u1 = 1'b0; tbl.push_back(t);
    t = '0; t.in = idle; t.in.ex_load = 1'b1; t.in.ex_rd = 5'd0; t.in.id_rs1 = 5'd0;
    t.in.id_u1 = 1'b1; tbl.push_back(t);
    t = '0; t.in = idle; t.in.ex_load = 1'b0; t.in.ex_rd = 5'd9; t.in.id_rs2 = 5'd9;
    t.in.id_u2 = 1'b1; tbl.push_back(t);
    t = '0; t.in = idle; t.in.jmp = 1'b1; t.exp.ifid = 1'b1; t.exp.flush = 1'b1;
    tbl.push_back(t);
    foreach (tbl[i]) begin
      step("table", tbl[i].in);
      check($sformatf("table[%0d]", i), 32'(last), 32'(tbl[i].exp));
    end

    // Random traffic on a small register range, with a reset every 250 cycles.
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) do_reset("random reset");
      v.id_rs1  = 5'($urandom_range(0, 3));
      v.id_rs2  = 5'($urandom_range(0, 3));
      v.id_u1   = 1'($urandom);
      v.id_u2   = 1'($urandom);
      v.ex_rs1  = 5'($urandom_range(0, 3));
      v.ex_rs2  = 5'($urandom_range(0, 3));
      v.ex_rd   = 5'($urandom_range(0, 3));
      v.ex_load = 1'($urandom);
      v.mem_rd  = 5'($urandom_range(0, 3));
      v.mem_wr  = 1'($urandom);
      v.wb_rd   = 5'($urandom_range(0, 3));
      v.wb_wr   = 1'($urandom);
      v.br      = ($urandom_range(0, 5) == 0);
      v.jmp     = ($urandom_range(0, 7) == 0);
      v.req     = ($urandom_range(0, 3) != 0);
      v.rdy     = ($urandom_range(0, 2) != 0);
      step("random", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Hazard detection and forwarding unit for the 5-stage pipelined core. It produces the `i_hazard_stall` / `i_hazard_flush` pair consumed by pipelined_control. It consumes that unit's `o_CTL_ex_is_load` and `o_CTL_mem_reg_write` outputs, plus register indices from the datapath. It also owns a data-memory wait FSM that freezes the pipeline, with a timeout error and performance counters.

Parameters:
MEM_TIMEOUT, 255, consecutive not-ready data-memory cycles before entering ERROR (must be ≥2).
CNT_W, 32, width of the performance counters.

Ports:
i_clk  input  1  clock
i_reset  input  1  reset, asynchronous, active-high
i_id_rs1  input  5  rs1 of the instruction in ID
i_id_rs2  input  5  rs2 of the instruction in ID
i_id_uses_rs1  input  1  ID instruction reads rs1
i_id_uses_rs2  input  1  ID instruction reads rs2
i_ex_rs1  input  5  rs1 of the instruction in EX
i_ex_rs2  input  5  rs2 of the instruction in EX
i_ex_rd  input  5  rd of the instruction in EX
i_ex_is_load  input  1  EX instruction is a load (from control `o_CTL_ex_is_load`)
i_mem_rd  input  5  rd of the instruction in MEM
i_mem_reg_write  input  1  MEM instruction writes rd (from control `o_CTL_mem_reg_write`)
i_wb_rd  input  5  rd of the instruction in WB
i_wb_reg_write  input  1  WB instruction writes rd
i_branch_taken  input  1  taken branch resolved in EX
i_jump_taken  input  1  jump resolved in EX
i_dmem_req  input  1  MEM stage has an active load/store
i_dmem_ready  input  1  data memory completes the access this cycle
o_hazard_stall  output  1  hold PC and IF/ID
o_hazard_flush  output  1  bubble ID/EX
o_if_id_flush  output  1  squash IF/ID
o_freeze  output  1  hold every pipeline register and the PC
o_fwd_a  output  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
o_fwd_b  output  2  EX operand B source, same encoding
o_mem_timeout  output  1  sticky error flag
o_stall_cycles  output  CNT_W  cycles with stall or freeze asserted
o_flush_count  output  CNT_W  redirect events

Behaviour:
- Reset (async, active-high): state=RUN, wait counter=0, both perf counters=0, o_mem_timeout=0.
- All hazard and forwarding outputs are combinational from the inputs plus state. During reset, drive them as in RUN with no hazard: all 0.
- Memory wait:
  - mem_wait = i_dmem_req && !i_dmem_ready.
  - In RUN and MEM_WAIT, o_freeze = mem_wait.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN → MEM_WAIT on mem_wait; wait counter loads 1.
  - MEM_WAIT stays while mem_wait; the counter increments each cycle.
  - MEM_WAIT → RUN when !mem_wait; the counter clears.
  - Entering ERROR: at the edge where the counter would reach MEM_TIMEOUT, state=ERROR. For example, with MEM_TIMEOUT=4 and ready low from cycle 0, ERROR is entered from cycle 4.
  - ERROR is terminal until reset: o_freeze=1, o_mem_timeout=1, all other hazard outputs 0.
- Priority for stall/flush: freeze > redirect > load-use.
  - While o_freeze=1: o_hazard_stall=0, o_hazard_flush=0, o_if_id_flush=0.
  - A branch or jump held in EX during freeze is therefore redirected in the first unfrozen cycle.
- Redirect (i_branch_taken || i_jump_taken, not frozen):
  - o_if_id_flush=1 and o_hazard_flush=1, o_hazard_stall=0 (PC loads the target).
  - o_flush_count increments once per cycle in which a redirect is applied.
- Load-use (not frozen, no redirect):
  - Condition: i_ex_is_load && i_ex_rd!=0 && ((i_id_uses_rs1 && i_id_rs1==i_ex_rd) || (i_id_uses_rs2 && i_id_rs2==i_ex_rd)).
  - Response: o_hazard_stall=1 and o_hazard_flush=1 (control gives flush precedence, so a bubble is inserted).
  - Exactly one bubble per load-use. The next cycle the load is in MEM and no hazard re-asserts.
- Forwarding, per operand X in {rs1→o_fwd_a, rs2→o_fwd_b}:
  - 01 if i_mem_reg_write && i_mem_rd!=0 && i_mem_rd==X.
  - Else 10 if i_wb_reg_write && i_wb_rd!=0 && i_wb_rd==X.
  - Else 00.
  - MEM has priority over WB. Forwarding is independent of freeze and flush.
- Counters:
  - o_stall_cycles increments each cycle with (o_hazard_stall || o_freeze), including ERROR.
  - Both counters wrap modulo 2^CNT_W, with no saturation.
- Reset mid-wait: returns to RUN immediately; the counter clears; o_mem_timeout clears.

Test Plan:
- Load x5 in EX, ID add reads rs2=x5 → exactly 1 cycle of stall=1, flush=1. Next cycle, with the load in MEM: stall=0, flush=0. The following cycle, with the add in EX and the load in WB: o_fwd_b=10. o_stall_cycles=1.
- Back-to-back ALU ops: MEM rd=x3 reg_write, WB rd=x3 reg_write, EX rs1=x3 → o_fwd_a=01. Same with MEM rd=x0 → o_fwd_a=10. With rd=x0 in both → 00.
- Branch taken in EX while a load-use condition is also present → if_id_flush=1, hazard_flush=1, stall=0; o_flush_count 0→1.
- dmem_req=1, ready low 3 cycles, then high → o_freeze=1 for 3 cycles, state back to RUN, o_stall_cycles=3. A branch_taken held during the freeze → flushes asserted only on the cycle after ready.
- MEM_TIMEOUT=4, dmem_req=1, ready held low → o_mem_timeout=1 from cycle 4. o_freeze stays 1 even after ready rises. Async reset asserted mid-clock → all outputs 0 immediately.
- Counter wrap with CNT_W=4: 17 stall cycles → o_stall_cycles=1.
